gemm_tile_mac_engine: RTL and testbench

Responder side of the tile compute handshake driven by the tiled GEMM controller. It accepts start with cfg_m/cfg_n/cfg_k, and computes C_buf[i][j] = sum over kk of A_buf[i][kk]*B_buf[kk][j] for one tile using COLS parallel MAC lanes, one (row, k) step per cycle. It reports busy, then a one-cycle done. It drops into the same slot as the systolic core: same port shapes and the same handshake.

---
 rtl/backbone_pkg.sv | 15 +
 rtl/gemm_tile_mac_engine_if.sv | 16 +
 rtl/gemm_mac_lane_row.sv | 41 ++++
 rtl/gemm_tile_mac_engine.sv | 136 +++++++++++++
 tb/tb_gemm_tile_mac_engine.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/backbone_pkg.sv
// Shared datapath widths and the tile MAC engine state type.
package backbone_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 48;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    DRAIN,
    DONE
  } mac_state_t;

endpackage

// File: rtl/gemm_tile_mac_engine_if.sv
// Tile compute handshake between the GEMM controller (master) and a tile engine (slave).
interface gemm_tile_mac_engine_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int K_MAX = 2048
);
  logic                         start;
  logic [$clog2(ROWS+1)-1:0]    cfg_m;
  logic [$clog2(COLS+1)-1:0]    cfg_n;
  logic [$clog2(K_MAX+1)-1:0]   cfg_k;
  logic                         busy;
  logic                         done;

  modport master (output start, cfg_m, cfg_n, cfg_k, input busy, done);
  modport slave  (input start, cfg_m, cfg_n, cfg_k, output busy, done);
endinterface

// File: rtl/gemm_mac_lane_row.sv
// COLS parallel multipliers: one A scalar against a B row slice, registered, with
// a valid bit and row tag that tell the accumulator stage where to add.
module gemm_mac_lane_row #(
  parameter int COLS     = 16,
  parameter int RI_W     = 4,
  parameter int DATA_W_P = 16,
  parameter int ACC_W_P  = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [RI_W-1:0]            row_in,
  input  logic signed [DATA_W_P-1:0] a,
  input  logic signed [DATA_W_P-1:0] b_row [COLS],
  input  logic [COLS-1:0]            n_mask,
  output logic                       valid_out,
  output logic [RI_W-1:0]            row_out,
  output logic signed [ACC_W_P-1:0]  prod [COLS]
);

  localparam int PW = 2 * DATA_W_P;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      row_out   <= '0;
      for (int j = 0; j < COLS; j++) prod[j] <= '0;
    end else begin
      valid_out <= valid_in;
      row_out   <= row_in;
      // Masked lanes carry zero so a stray enable can never disturb inactive columns.
      for (int j = 0; j < COLS; j++) begin
        if (valid_in && n_mask[j])
          prod[j] <= ACC_W_P'(PW'(a) * PW'(b_row[j]));
        else
          prod[j] <= '0;
      end
    end
  end

endmodule

// File: rtl/gemm_tile_mac_engine.sv
// Tile MAC engine: C = A*B over one tile, one (row, k) step per cycle across COLS lanes,
// with a one-deep product pipeline committed into the registered C_buf file.
module gemm_tile_mac_engine
  import backbone_pkg::*;
#(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int K_MAX    = 2048,
  parameter int DATA_W_P = DATA_W,
  parameter int ACC_W_P  = ACC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  gemm_tile_mac_engine_if.slave      ctrl,
  input  logic signed [DATA_W_P-1:0] A_buf [ROWS][K_MAX],
  input  logic signed [DATA_W_P-1:0] B_buf [K_MAX][COLS],
  output logic signed [ACC_W_P-1:0]  C_buf [ROWS][COLS]
);

  localparam int MW   = $clog2(ROWS + 1);
  localparam int NW   = $clog2(COLS + 1);
  localparam int KW   = $clog2(K_MAX + 1);
  localparam int RI_W = $clog2(ROWS);
  localparam int KI_W = $clog2(K_MAX);

  mac_state_t state_reg, state_next;

  logic [MW-1:0]   m_reg;
  logic [NW-1:0]   n_reg;
  logic [KW-1:0]   k_reg;
  logic [RI_W-1:0] i_reg;
  logic [KI_W-1:0] kk_reg;

  logic                       k_last, last_issue, issue;
  logic [COLS-1:0]            n_mask;
  logic signed [DATA_W_P-1:0] b_row [COLS];
  logic                       lane_valid;
  logic [RI_W-1:0]            lane_row;
  logic signed [ACC_W_P-1:0]  lane_prod [COLS];

  assign issue      = (state_reg == MAC);
  assign k_last     = (KW'(kk_reg) == k_reg - KW'(1));
  assign last_issue = issue && k_last && (MW'(i_reg) == m_reg - MW'(1));

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_lane_in
      assign n_mask[gi] = (NW'(gi) < n_reg);
      assign b_row[gi]  = B_buf[kk_reg][gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ctrl.busy  = (state_reg != IDLE);
    ctrl.done  = (state_reg == DONE);
    case (state_reg)
      IDLE:  if (ctrl.start) state_next = CLEAR;
      CLEAR: state_next = (m_reg == '0 || n_reg == '0 || k_reg == '0) ? DONE : MAC;
      MAC:   if (last_issue) state_next = DRAIN;
      DRAIN: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Config latch and the (i, kk) issue counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg  <= '0;
      n_reg  <= '0;
      k_reg  <= '0;
      i_reg  <= '0;
      kk_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (ctrl.start) begin
          m_reg <= (ctrl.cfg_m > MW'(ROWS))  ? MW'(ROWS)  : ctrl.cfg_m;
          n_reg <= (ctrl.cfg_n > NW'(COLS))  ? NW'(COLS)  : ctrl.cfg_n;
          k_reg <= (ctrl.cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : ctrl.cfg_k;
        end
        CLEAR: begin
          i_reg  <= '0;
          kk_reg <= '0;
        end
        MAC: begin
          if (k_last) begin
            kk_reg <= '0;
            i_reg  <= i_reg + RI_W'(1);
          end else begin
            kk_reg <= kk_reg + KI_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  gemm_mac_lane_row #(
    .COLS     (COLS),
    .RI_W     (RI_W),
    .DATA_W_P (DATA_W_P),
    .ACC_W_P  (ACC_W_P)
  ) u_lane_row (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (issue),
    .row_in    (i_reg),
    .a         (A_buf[i_reg][kk_reg]),
    .b_row     (b_row),
    .n_mask    (n_mask),
    .valid_out (lane_valid),
    .row_out   (lane_row),
    .prod      (lane_prod)
  );

  // Accumulation wraps modulo 2^ACC_W_P by design.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) C_buf[r][c] <= '0;
    end else if (state_reg == CLEAR) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) C_buf[r][c] <= '0;
    end else if (lane_valid) begin
      for (int c = 0; c < COLS; c++)
        C_buf[lane_row][c] <= C_buf[lane_row][c] + lane_prod[c];
    end
  end

endmodule

// File: tb/tb_gemm_tile_mac_engine.sv
// Randomized and directed checks of the tile MAC engine against a plain-arithmetic matrix model.
module tb_gemm_tile_mac_engine;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int K_MAX = 8;
  localparam int DW    = 8;
  localparam int AW    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic signed [DW-1:0] A_buf [ROWS][K_MAX];
  logic signed [DW-1:0] B_buf [K_MAX][COLS];
  logic signed [AW-1:0] C_buf [ROWS][COLS];

  int total = 0;
  int bad   = 0;

  gemm_tile_mac_engine_if #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) bus ();

  gemm_tile_mac_engine #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .K_MAX    (K_MAX),
    .DATA_W_P (DW),
    .ACC_W_P  (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus),
    .A_buf (A_buf),
    .B_buf (B_buf),
    .C_buf (C_buf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: random, 1: A=1/B=2, 2: A=B=-128
  task automatic fill(input int mode);
    for (int i = 0; i < ROWS; i++)
      for (int kk = 0; kk < K_MAX; kk++) begin
        if (mode == 0)      A_buf[i][kk] = DW'($urandom);
        else if (mode == 1) A_buf[i][kk] = 8'sd1;
        else                A_buf[i][kk] = -8'sd128;
      end
    for (int kk = 0; kk < K_MAX; kk++)
      for (int j = 0; j < COLS; j++) begin
        if (mode == 0)      B_buf[kk][j] = DW'($urandom);
        else if (mode == 1) B_buf[kk][j] = 8'sd2;
        else                B_buf[kk][j] = -8'sd128;
      end
  endtask

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic signed [AW-1:0] model(input int i, input int j, input int m, input int n, input int k);
    int acc;
    acc = 0;
    if (i >= clampi(m, ROWS) || j >= clampi(n, COLS)) return '0;
    for (int kk = 0; kk < clampi(k, K_MAX); kk++)
      acc += int'(A_buf[i][kk]) * int'(B_buf[kk][j]);
    return AW'(acc);
  endfunction

  function automatic int nonzero_c();
    int cnt;
    cnt = 0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        if (C_buf[i][j] !== '0) cnt++;
    return cnt;
  endfunction

  task automatic run(input int m, input int n, input int k, input bit pulse_mid,
                     input bit pulse_done, input string tag);
    int ms, ns, ks, exp_done, done_cyc, done_cnt, busy_err;
    ms = clampi(m, ROWS);
    ns = clampi(n, COLS);
    ks = clampi(k, K_MAX);
    exp_done = (ms == 0 || ns == 0 || ks == 0) ? 2 : 3 + ms * ks;
    done_cyc = -1;
    done_cnt = 0;
    busy_err = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_m = m[2:0];
    bus.cfg_n = n[2:0];
    bus.cfg_k = k[3:0];
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.busy !== (cyc <= exp_done)) busy_err++;
      bus.start = (pulse_mid && exp_done > 4 && cyc == exp_done / 2) ||
                  (pulse_done && cyc == exp_done);
      if (bus.start) begin
        bus.cfg_m = 3'd1;
        bus.cfg_n = 3'd1;
        bus.cfg_k = 4'd1;
      end
    end
    bus.start = 1'b0;
    $display("run %s m=%0d n=%0d k=%0d done_cycle=%0d dones=%0d", tag, m, n, k, done_cyc, done_cnt);
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_busy_window_errs"}, busy_err, 0);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        chk($sformatf("%s_C%0d%0d", tag, i, j), C_buf[i][j], model(i, j, m, n, k));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cfg_m = '0;
    bus.cfg_n = '0;
    bus.cfg_k = '0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_c_nonzero", nonzero_c(), 0);
    rst_n = 1'b1;

    fill(1); run(4, 4, 8, 0, 0, "ones");
    fill(0); run(3, 2, 5, 0, 0, "rand325");
    run(4, 4, 0, 0, 0, "k0");
    run(0, 4, 4, 0, 0, "m0");
    fill(2); run(4, 4, 8, 0, 0, "wrap");
    fill(0); run(4, 4, 8, 1, 1, "ignore");
    run(2, 3, 4, 0, 0, "after");
    run(7, 3, 15, 0, 0, "sat");

    // Reset asserted in the middle of a MAC run.
    fill(0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_m = 3'd4;
    bus.cfg_n = 3'd4;
    bus.cfg_k = 4'd8;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("run mid_rst busy=%0d done=%0d nonzero=%0d", bus.busy, bus.done, nonzero_c());
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_c_nonzero", nonzero_c(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(4, 4, 8, 0, 0, "post_rst");

    for (int t = 0; t < 3; t++) begin
      fill(0);
      run($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 8), 0, 0,
          $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
